// File: rtl/arrow_pkg.sv
// Shared lane constants, judgement encoding and track defaults for the arrow lane judge.
package arrow_pkg;

   localparam int NUM_LANES     = 4;
   localparam int LANE_UP       = 3;
   localparam int LANE_DOWN     = 2;
   localparam int LANE_LEFT     = 1;
   localparam int LANE_RIGHT    = 0;
   localparam int TRACK_LEN_DEF = 16;
   localparam int HIT_POS_DEF   = 13;

   typedef enum logic [1:0] {J_NONE, J_PERFECT, J_GOOD, J_MISS} judge_e;

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/arrow_lane.sv
// One lane: arrow shift register, hit-window judge and exit detect.
// Optional macro STRAY_PRESS_PENALTY_EN turns a press on an empty window into a miss.
module arrow_lane
   import arrow_pkg::*;
#(
   parameter int TRACK_LEN = TRACK_LEN_DEF,
   parameter int HIT_POS   = HIT_POS_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en_i,
   input  logic                 game_clear_i,
   input  logic                 spawn_i,
   input  logic                 step_i,
   input  logic                 press_i,
   output logic [TRACK_LEN-1:0] occ_o,
   output judge_e               judge_o,
   output logic                 exit_o
);

   logic [TRACK_LEN-1:0] occ_q, occ_d;
   logic [TRACK_LEN-1:0] clr_mask, kept, shifted;

   always_comb begin
      clr_mask = '0;
      judge_o  = J_NONE;
      if (press_i) begin
         // Older arrow (HIT_POS+1) beats the younger one when both flank the target.
         if (occ_q[HIT_POS]) begin
            clr_mask[HIT_POS] = 1'b1;
            judge_o           = J_PERFECT;
         end else if (occ_q[HIT_POS+1]) begin
            clr_mask[HIT_POS+1] = 1'b1;
            judge_o             = J_GOOD;
         end else if (occ_q[HIT_POS-1]) begin
            clr_mask[HIT_POS-1] = 1'b1;
            judge_o             = J_GOOD;
         end
`ifdef STRAY_PRESS_PENALTY_EN
         else begin
            judge_o = J_MISS;
         end
`endif
      end
      kept    = occ_q & ~clr_mask;
      exit_o  = step_i & kept[TRACK_LEN-1];
      shifted = step_i ? {kept[TRACK_LEN-2:0], 1'b0} : kept;
      occ_d   = shifted | {{(TRACK_LEN-1){1'b0}}, spawn_i};
      if (game_clear_i) begin
         occ_d   = '0;
         judge_o = J_NONE;
         exit_o  = 1'b0;
      end else if (!en_i) begin
         occ_d   = occ_q;
         judge_o = J_NONE;
         exit_o  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) occ_q <= '0;
      else       occ_q <= occ_d;
   end

   assign occ_o = occ_q;

endmodule

// File: rtl/arrow_lane_judge.sv
// Four arrow lanes plus input edge detection, registered judge pulses, score and combo tracking.
// Optional macro STRAY_PRESS_PENALTY_EN (handled in arrow_lane) penalises presses on an empty window.
module arrow_lane_judge
   import arrow_pkg::*;
#(
   parameter int TRACK_LEN   = TRACK_LEN_DEF,
   parameter int HIT_POS     = HIT_POS_DEF,
   parameter int PERFECT_PTS = 2,
   parameter int GOOD_PTS    = 1,
   parameter int SCORE_W     = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           game_active,
   input  logic [3:0]                     pattern_in,
   input  logic                           pattern_valid,
   input  logic                           step_tick,
   input  logic [3:0]                     key_in,
   output logic [NUM_LANES*TRACK_LEN-1:0] lane_occ,
   output logic [3:0]                     judge_perfect,
   output logic [3:0]                     judge_good,
   output logic [3:0]                     judge_miss,
   output logic [SCORE_W-1:0]             score,
   output logic [7:0]                     combo,
   output logic [7:0]                     max_combo
);

   logic               pattern_valid_q, game_active_q;
   logic [3:0]         key_q;
   logic               game_clear;
   logic [3:0]         spawn, press;
   logic [3:0]         perfect_d, good_d, miss_d;
   logic [3:0]         perfect_q, good_q, miss_q;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [7:0]         combo_q, combo_d, max_q, max_d;
   logic [15:0]        pts;
   logic [SCORE_W+16:0] score_sum;
   logic [8:0]         combo_sum;

   assign game_clear = game_active & ~game_active_q;
   assign spawn      = pattern_in & {4{pattern_valid & ~pattern_valid_q}};
   assign press      = key_in & ~key_q;

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      judge_e               judge;
      logic                 exit_w;
      logic [TRACK_LEN-1:0] occ;

      arrow_lane #(
         .TRACK_LEN (TRACK_LEN),
         .HIT_POS   (HIT_POS)
      ) u_lane (
         .clock        (clock),
         .reset        (reset),
         .en_i         (game_active),
         .game_clear_i (game_clear),
         .spawn_i      (spawn[l]),
         .step_i       (step_tick),
         .press_i      (press[l]),
         .occ_o        (occ),
         .judge_o      (judge),
         .exit_o       (exit_w)
      );

      assign lane_occ[l*TRACK_LEN +: TRACK_LEN] = occ;
      assign perfect_d[l] = (judge == J_PERFECT);
      assign good_d[l]    = (judge == J_GOOD);
      assign miss_d[l]    = exit_w | (judge == J_MISS);
   end

   always_comb begin
      pts       = 16'(PERFECT_PTS * int'(popcount4(perfect_d)) + GOOD_PTS * int'(popcount4(good_d)));
      score_sum = (SCORE_W+17)'(score_q) + (SCORE_W+17)'(pts);
      score_d   = (score_sum > (SCORE_W+17)'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : score_q + SCORE_W'(pts);
      combo_sum = 9'(combo_q) + 9'(popcount4(perfect_d | good_d));
      // A miss anywhere in the cycle breaks the streak even if other lanes hit.
      if (|miss_d)              combo_d = 8'd0;
      else if (combo_sum > 255) combo_d = 8'd255;
      else                      combo_d = combo_sum[7:0];
      max_d = (combo_d > max_q) ? combo_d : max_q;
      if (game_clear) begin
         score_d = '0;
         combo_d = '0;
         max_d   = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pattern_valid_q <= 1'b0;
         game_active_q   <= 1'b0;
         key_q           <= '0;
         perfect_q       <= '0;
         good_q          <= '0;
         miss_q          <= '0;
         score_q         <= '0;
         combo_q         <= '0;
         max_q           <= '0;
      end else begin
         pattern_valid_q <= pattern_valid;
         game_active_q   <= game_active;
         key_q           <= key_in;
         perfect_q       <= perfect_d;
         good_q          <= good_d;
         miss_q          <= miss_d;
         score_q         <= score_d;
         combo_q         <= combo_d;
         max_q           <= max_d;
      end
   end

   assign judge_perfect = perfect_q;
   assign judge_good    = good_q;
   assign judge_miss    = miss_q;
   assign score         = score_q;
   assign combo         = combo_q;
   assign max_combo     = max_q;

endmodule

// File: tb/tb_arrow_lane_judge.sv
// Directed bench for arrow_lane_judge with a queue-based arrow model checked every cycle.
module tb_arrow_lane_judge;
   import arrow_pkg::*;

   localparam int TL  = 16;
   localparam int HIT = 13;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        game_active = 1'b0;
   logic [3:0]  pattern_in = '0;
   logic        pattern_valid = 1'b0;
   logic        step_tick = 1'b0;
   logic [3:0]  key_in = '0;
   logic [63:0] lane_occ;
   logic [3:0]  judge_perfect, judge_good, judge_miss;
   logic [15:0] score;
   logic [7:0]  combo, max_combo;

   int tests = 0;
   int fails = 0;

   arrow_lane_judge dut (
      .clock         (clock),
      .reset         (reset),
      .game_active   (game_active),
      .pattern_in    (pattern_in),
      .pattern_valid (pattern_valid),
      .step_tick     (step_tick),
      .key_in        (key_in),
      .lane_occ      (lane_occ),
      .judge_perfect (judge_perfect),
      .judge_good    (judge_good),
      .judge_miss    (judge_miss),
      .score         (score),
      .combo         (combo),
      .max_combo     (max_combo)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model: arrows as lists of positions ----------------
   int         q[4][$];
   bit         m_on = 0;
   bit [3:0]   m_perf, m_good, m_miss;
   int         m_score, m_combo, m_max;
   bit         p_pv, p_ga;
   bit [3:0]   p_key;

   function automatic int find_arrow(int l, int p);
      for (int i = 0; i < q[l].size(); i++) if (q[l][i] == p) return i;
      return -1;
   endfunction

   function automatic logic [63:0] model_occ();
      logic [63:0] o = '0;
      for (int l = 0; l < 4; l++)
         for (int i = 0; i < q[l].size(); i++) o[l*TL + q[l][i]] = 1'b1;
      return o;
   endfunction

   always @(posedge clock) begin
      int idx;
      m_perf = '0; m_good = '0; m_miss = '0;
      if (reset) begin
         for (int l = 0; l < 4; l++) q[l].delete();
         m_score = 0; m_combo = 0; m_max = 0;
         p_pv = 0; p_ga = 0; p_key = '0;
         m_on = 1;
      end else begin
         if (game_active && !p_ga) begin
            for (int l = 0; l < 4; l++) q[l].delete();
            m_score = 0; m_combo = 0; m_max = 0;
         end else if (game_active) begin
            for (int l = 0; l < 4; l++) begin
               if (key_in[l] && !p_key[l]) begin
                  idx = find_arrow(l, HIT);
                  if (idx >= 0) begin q[l].delete(idx); m_perf[l] = 1; end
                  else begin
                     idx = find_arrow(l, HIT + 1);
                     if (idx < 0) idx = find_arrow(l, HIT - 1);
                     if (idx >= 0) begin q[l].delete(idx); m_good[l] = 1; end
`ifdef STRAY_PRESS_PENALTY_EN
                     else m_miss[l] = 1;
`endif
                  end
               end
               if (step_tick)
                  for (int i = q[l].size() - 1; i >= 0; i--) begin
                     q[l][i] = q[l][i] + 1;
                     if (q[l][i] >= TL) begin q[l].delete(i); m_miss[l] = 1; end
                  end
               if (pattern_valid && !p_pv && pattern_in[l]) q[l].push_back(0);
            end
            m_score = m_score + 2 * $countones(m_perf) + $countones(m_good);
            if (m_score > 65535) m_score = 65535;
            if (m_miss != 0) m_combo = 0;
            else m_combo = m_combo + $countones(m_perf | m_good);
            if (m_combo > 255) m_combo = 255;
            if (m_combo > m_max) m_max = m_combo;
         end
         p_pv = pattern_valid; p_ga = game_active; p_key = key_in;
      end
   end

   always @(negedge clock) begin
      if (m_on) begin
         chk("occ", lane_occ, model_occ());
         chk("perfect", 64'(judge_perfect), 64'(m_perf));
         chk("good", 64'(judge_good), 64'(m_good));
         chk("miss", 64'(judge_miss), 64'(m_miss));
         chk("score", 64'(score), 64'(m_score));
         chk("combo", 64'(combo), 64'(m_combo));
         chk("max_combo", 64'(max_combo), 64'(m_max));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic insert(input logic [3:0] p);
      pattern_in = p; pattern_valid = 1'b1;
      tick();
      pattern_valid = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         step_tick = 1'b1;
         tick();
      end
      step_tick = 1'b0;
   endtask

   task automatic press(input logic [3:0] k, input logic st);
      key_in = k; step_tick = st;
      tick();
      key_in = '0; step_tick = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] up, left, right, down;
      up = 4'(1 << LANE_UP); down = 4'(1 << LANE_DOWN);
      left = 4'(1 << LANE_LEFT); right = 4'(1 << LANE_RIGHT);

      repeat (3) tick();
      chk("rst_occ", lane_occ, 64'h0);
      chk("rst_score", 64'(score), 64'h0);
      chk("rst_judge", 64'({judge_perfect, judge_good, judge_miss}), 64'h0);
      reset = 1'b0; game_active = 1'b1;
      tick();

      // insert and perfect
      insert(up);
      steps(13);
      chk("t1_occ", lane_occ, 64'h1 << 61);
      press(up, 1'b0);
      chk("t1_perfect", 64'(judge_perfect), 64'h8);
      chk("t1_score", 64'(score), 64'd2);
      chk("t1_combo", 64'(combo), 64'd1);
      chk("t1_occ_after", lane_occ, 64'h0);

      // level held high inserts once, then exits as misses
      pattern_in = down | right; pattern_valid = 1'b1;
      repeat (5) tick();
      pattern_valid = 1'b0;
      chk("t2_occ", lane_occ, 64'h0000_0001_0000_0001);
      steps(15);
      chk("t2_occ15", lane_occ, (64'h1 << 47) | (64'h1 << 15));
      steps(1);
      chk("t2_miss", 64'(judge_miss), 64'h5);
      chk("t2_combo", 64'(combo), 64'd0);
      chk("t2_score", 64'(score), 64'd2);

      // good window, older arrow wins
      insert(left);
      steps(2);
      insert(left);
      steps(12);
      chk("t3_occ", lane_occ, (64'h1 << 30) | (64'h1 << 28));
      press(left, 1'b0);
      chk("t3_good", 64'(judge_good), 64'h2);
      chk("t3_score", 64'(score), 64'd3);
      chk("t3_occ_after", lane_occ, 64'h1 << 28);

      // press+step on a perfect while another lane exits
      steps(4);
      insert(right);
      steps(2);
      insert(up);
      steps(13);
      chk("t4_occ", lane_occ, (64'h1 << 61) | (64'h1 << 15));
      press(up, 1'b1);
      chk("t4_perfect", 64'(judge_perfect), 64'h8);
      chk("t4_miss", 64'(judge_miss), 64'h1);
      chk("t4_combo", 64'(combo), 64'd0);
      chk("t4_score", 64'(score), 64'd5);
      chk("t4_occ_after", lane_occ, 64'h0);

      // 300 perfects saturate the combo
      pattern_in = 4'hF;
      for (int c = 0; c < 164; c++) begin
         step_tick = 1'b1;
         pattern_valid = (c % 2 == 0) && (c < 150);
         key_in = ((c % 2 == 0) && (c >= 14)) ? 4'hF : 4'h0;
         tick();
      end
      step_tick = 1'b0; pattern_valid = 1'b0; key_in = '0;
      chk("t5_combo", 64'(combo), 64'd255);
      chk("t5_max", 64'(max_combo), 64'd255);
      chk("t5_score", 64'(score), 64'd605);

      // inactive holds state; new game clears it
      insert(4'hF);
      game_active = 1'b0;
      tick();
      press(4'hF, 1'b1);
      chk("t5_hold_occ", lane_occ, 64'h0001_0001_0001_0001);
      chk("t5_hold_score", 64'(score), 64'd605);
      chk("t5_hold_judge", 64'(judge_perfect | judge_miss), 64'h0);
      game_active = 1'b1;
      tick();
      chk("t5_new_occ", lane_occ, 64'h0);
      chk("t5_new_cnt", 64'({score, combo, max_combo}), 64'h0);

      // stray press
      insert(down);
      steps(13);
      press(down, 1'b0);
      chk("t6_perfect", 64'(judge_perfect), 64'h4);
      press(right, 1'b0);
`ifdef STRAY_PRESS_PENALTY_EN
      chk("t6_stray_miss", 64'(judge_miss), 64'h1);
      chk("t6_stray_combo", 64'(combo), 64'd0);
`else
      chk("t6_stray_miss", 64'(judge_miss), 64'h0);
      chk("t6_stray_combo", 64'(combo), 64'd1);
`endif
      chk("t6_stray_score", 64'(score), 64'd2);

      // reset mid-game
      insert(4'hF);
      steps(3);
      reset = 1'b1;
      tick();
      chk("t7_occ", lane_occ, 64'h0);
      chk("t7_cnt", 64'({score, combo, max_combo}), 64'h0);
      reset = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
